// File: rtl/demux_1ne4_reg.sv
// Registered 1-to-4 demultiplexer with a one-entry holding register per channel.
// Optional accept counter output Numeruesi is enabled by defining DEMUX_1NE4_CNT_EN.
module demux_1ne4_reg #(
    parameter int W = 24
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic [W-1:0] Hyrja,
    input  logic         HyrjaValid,
    output logic         HyrjaReady,
    input  logic [1:0]   S,
    input  logic         Mode,
    output logic [W-1:0] Dalja0,
    output logic [W-1:0] Dalja1,
    output logic [W-1:0] Dalja2,
    output logic [W-1:0] Dalja3,
    output logic [3:0]   DaljaValid,
    input  logic [3:0]   DaljaReady,
`ifdef DEMUX_1NE4_CNT_EN
    output logic [15:0]  Numeruesi,
`endif
    output logic [1:0]   Ptr
);

    logic [W-1:0] dalja_q [4];
    logic [1:0]   target;
    logic         accept;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        target     = S;
        HyrjaReady = 1'b0;
        if (Mode) begin
            target = Ptr;
        end
        HyrjaReady = !DaljaValid[target] || DaljaReady[target];
    end

    assign accept = HyrjaValid && HyrjaReady;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    // NOTE: the data registers are reset too, because channels must read as zero
    // after reset; holding registers here are flops, not a RAM.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 4; i++) begin
                dalja_q[i] <= '0;
            end
            DaljaValid <= 4'b0000;
            Ptr        <= 2'b00;
        end else begin
            for (int i = 0; i < 4; i++) begin
                // A load wins over a drain, which gives back-to-back throughput.
                if (accept && (target == 2'(i))) begin
                    dalja_q[i]    <= Hyrja;
                    DaljaValid[i] <= 1'b1;
                end else if (DaljaValid[i] && DaljaReady[i]) begin
                    DaljaValid[i] <= 1'b0;
                end
            end
            if (accept && Mode) begin
                Ptr <= Ptr + 2'd1;
            end
        end
    end

`ifdef DEMUX_1NE4_CNT_EN
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Numeruesi <= 16'h0000;
        end else if (accept) begin
            Numeruesi <= Numeruesi + 16'd1;
        end
    end
`endif

    assign Dalja0 = dalja_q[0];
    assign Dalja1 = dalja_q[1];
    assign Dalja2 = dalja_q[2];
    assign Dalja3 = dalja_q[3];

endmodule

// File: tb/tb_demux_1ne4_reg.sv
// Self-checking bench for demux_1ne4_reg: directed steps plus randomized traffic
// compared against an array-based reference model of the channel registers.
module tb_demux_1ne4_reg;

    localparam int W = 24;

    logic         Clock = 1'b0;
    logic         Reset;
    logic [W-1:0] Hyrja;
    logic         HyrjaValid;
    logic         HyrjaReady;
    logic [1:0]   S;
    logic         Mode;
    logic [W-1:0] Dalja0, Dalja1, Dalja2, Dalja3;
    logic [3:0]   DaljaValid;
    logic [3:0]   DaljaReady;
    logic [1:0]   Ptr;
`ifdef DEMUX_1NE4_CNT_EN
    logic [15:0]  Numeruesi;
`endif

    always #5 Clock = ~Clock;

    demux_1ne4_reg #(.W(W)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Hyrja      (Hyrja),
        .HyrjaValid (HyrjaValid),
        .HyrjaReady (HyrjaReady),
        .S          (S),
        .Mode       (Mode),
        .Dalja0     (Dalja0),
        .Dalja1     (Dalja1),
        .Dalja2     (Dalja2),
        .Dalja3     (Dalja3),
        .DaljaValid (DaljaValid),
        .DaljaReady (DaljaReady),
`ifdef DEMUX_1NE4_CNT_EN
        .Numeruesi  (Numeruesi),
`endif
        .Ptr        (Ptr)
    );

    // Reference model: the four holding registers as plain arrays.
    logic [W-1:0] m_data [4];
    logic [3:0]   m_valid;
    logic [1:0]   m_ptr;
    logic [15:0]  m_cnt;
    int           checks   = 0;
    int           failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_data[i] = '0;
        m_valid = 4'b0000;
        m_ptr   = 2'b00;
        m_cnt   = 16'h0000;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".valid"}, 32'(DaljaValid), 32'(m_valid));
        check({tag, ".ptr"},   32'(Ptr),        32'(m_ptr));
        check({tag, ".d0"},    32'(Dalja0),     32'(m_data[0]));
        check({tag, ".d1"},    32'(Dalja1),     32'(m_data[1]));
        check({tag, ".d2"},    32'(Dalja2),     32'(m_data[2]));
        check({tag, ".d3"},    32'(Dalja3),     32'(m_data[3]));
`ifdef DEMUX_1NE4_CNT_EN
        check({tag, ".cnt"},   32'(Numeruesi),  32'(m_cnt));
`endif
    endtask

    // One clock cycle: drive, check readiness, clock, advance model, check state.
    task automatic step(input string tag, input logic hv, input logic [W-1:0] h,
                        input logic [1:0] s, input logic mode, input logic [3:0] dr);
        logic [1:0] t;
        logic       rdy;
        HyrjaValid = hv;
        Hyrja      = h;
        S          = s;
        Mode       = mode;
        DaljaReady = dr;
        #1;
        t   = mode ? m_ptr : s;
        rdy = !m_valid[t] || dr[t];
        check({tag, ".ready"}, 32'(HyrjaReady), 32'(rdy));
        @(posedge Clock);
        for (int i = 0; i < 4; i++) begin
            if (hv && rdy && t == 2'(i)) begin
                m_data[i]  = h;
                m_valid[i] = 1'b1;
            end else if (m_valid[i] && dr[i]) begin
                m_valid[i] = 1'b0;
            end
        end
        if (hv && rdy) begin
            m_cnt = m_cnt + 16'd1;
            if (mode) m_ptr = m_ptr + 2'd1;
        end
        #1;
        check_state(tag);
    endtask

    // Async reset applied between edges; called at posedge+1.
    task automatic pulse_reset(input string tag);
        Reset      = 1'b0;
        HyrjaValid = 1'b1;
        DaljaReady = 4'b0000;
        #1;
        model_reset();
        check_state({tag, ".async"});
        check({tag, ".ready_in_rst"}, 32'(HyrjaReady), 32'd1);
        @(posedge Clock);
        #1;
        check_state({tag, ".held"});
        HyrjaValid = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        check_state({tag, ".released"});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset      = 1'b0;
        Hyrja      = '0;
        HyrjaValid = 1'b0;
        S          = 2'b00;
        Mode       = 1'b0;
        DaljaReady = 4'b0000;
        model_reset();
        #2;
        check_state("rst0");
        @(negedge Clock);
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        check_state("rst0_rel");

        // Explicit select, then head-of-line stall on the same channel.
        step("sel_ch2", 1'b1, 24'hABCDEF, 2'd2, 1'b0, 4'b0000);
        check("sel_ch2.valid_c", 32'(DaljaValid), 32'h4);
        check("sel_ch2.data_c",  32'(Dalja2),     32'hABCDEF);
        step("sel_stall", 1'b1, 24'h123456, 2'd2, 1'b0, 4'b0000);
        check("sel_stall.data_c", 32'(Dalja2), 32'hABCDEF);

        // Drain and reload channel 1 in the same cycle, sustained.
        step("ld_ch1", 1'b1, 24'h000111, 2'd1, 1'b0, 4'b0000);
        step("reload1", 1'b1, 24'h000123, 2'd1, 1'b0, 4'b0010);
        check("reload1.data_c", 32'(Dalja1), 32'h000123);
        step("reload2", 1'b1, 24'h000124, 2'd1, 1'b0, 4'b0010);
        step("reload3", 1'b1, 24'h000125, 2'd1, 1'b0, 4'b0010);

        // Reset with words in flight.
        pulse_reset("rst_mid");

        // Round-robin wrap over six words.
        for (int k = 1; k <= 6; k++) begin
            step("rr_wrap", 1'b1, W'(k), 2'd0, 1'b1, 4'b1111);
        end
        check("rr_wrap.ptr_c", 32'(Ptr), 32'd2);
        check("rr_wrap.d0_c",  32'(Dalja0), 32'd5);
        check("rr_wrap.d3_c",  32'(Dalja3), 32'd4);

        // Round-robin stall at Ptr=3 with channel 3 full.
        step("rr_drain", 1'b0, '0, 2'd0, 1'b1, 4'b1111);
        step("rr_ch2", 1'b1, 24'h0000C2, 2'd0, 1'b1, 4'b0000);
        step("sel_ch3", 1'b1, 24'h0000C3, 2'd3, 1'b0, 4'b0000);
        step("rr_stall", 1'b1, 24'h0000D0, 2'd0, 1'b1, 4'b0000);
        check("rr_stall.ptr_c", 32'(Ptr), 32'd3);
        step("rr_go", 1'b1, 24'h0000D1, 2'd0, 1'b1, 4'b1000);
        check("rr_go.ptr_c",  32'(Ptr), 32'd0);
        check("rr_go.d3_c",   32'(Dalja3), 32'h0000D1);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            step("rand", 1'($urandom_range(0, 3) != 0), W'($urandom),
                 2'($urandom), 1'($urandom), 4'($urandom));
        end
        pulse_reset("rst_rand");

`ifdef DEMUX_1NE4_CNT_EN
        // Counter wraps after 65536 accepts.
        HyrjaValid = 1'b1;
        Hyrja      = 24'h00AAAA;
        S          = 2'd0;
        Mode       = 1'b0;
        DaljaReady = 4'b1111;
        repeat (65537) @(posedge Clock);
        #1;
        m_cnt     = 16'd1;
        m_valid   = 4'b0001;
        m_data[0] = 24'h00AAAA;
        check_state("cnt_wrap");
        pulse_reset("cnt_rst");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_1ne4_reg.md
Name: demux_1ne4_reg

Overview:
- Registered 1-to-4 demultiplexer for the 24-bit single-cycle CPU datapath; the reverse direction of the 4-to-1 selection muxes.
- Routes one input word stream to one of four output channels, each with a one-entry holding register.
- Target channel comes from explicit select S, or from an internal round-robin pointer.
- Used to fan write-back/result words out to four consumers with valid/ready flow control.

Parameters:
- W, 24, data width in bits of Hyrja and each Dalja channel.

Ports:
- Clock  input  1  single clock; all state changes on rising edge.
- Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- Hyrja  input  W  input data word.
- HyrjaValid  input  1  input word present.
- HyrjaReady  output  1  block can accept the input word this cycle.
- S  input  2  explicit target channel; used when Mode=0. 00→ch0, 01→ch1, 10→ch2, 11→ch3.
- Mode  input  1  0 = explicit select S; 1 = round-robin pointer.
- Dalja0, Dalja1, Dalja2, Dalja3  output  W each  channel data registers.
- DaljaValid  output  4  bit i = channel i holds a word.
- DaljaReady  input  4  bit i = consumer i takes the word this cycle.
- Ptr  output  2  current round-robin pointer value.

Behaviour:
- Target channel t = Mode ? Ptr : S. The target is combinational and is evaluated every cycle.
- HyrjaReady = !DaljaValid[t] | DaljaReady[t]. It is combinational and has no dependency on HyrjaValid.
- Input accept = HyrjaValid & HyrjaReady.
- Output handshake: channel i drains when DaljaValid[i] & DaljaReady[i].
- Per-channel update on each clock edge, in priority order:
  - Accept targeting i: Dalja_i <= Hyrja, DaljaValid[i] <= 1.
  - Else, drain on i: DaljaValid[i] <= 0; Dalja_i holds its last value.
  - Else: hold.
- Simultaneous drain and accept on the same channel: the new word is loaded and DaljaValid[i] stays 1 (full throughput, no bubble).
- Latency: a word accepted at edge N is visible on Dalja_t with DaljaValid[t]=1 after edge N. Maximum throughput is one word per cycle.
- Only one channel can be loaded per cycle. The other channels drain independently in the same cycle.
- Round-robin pointer:
  - Ptr advances by 1 modulo 4 on every accept while Mode=1; it wraps 3→0.
  - Ptr does not change while Mode=0 or when there is no accept.
- Mode switches take effect immediately in the same cycle. Ptr keeps its value across switches.
- Head-of-line blocking: if channel t is full and not draining, the input stalls. There is no skipping to another free channel.
- Changing S or HyrjaValid while stalled is legal. Data stability while stalled is not required, because nothing is captured until accept.
- DaljaReady with DaljaValid[i]=0 has no effect.
- Reset (Reset=0), at any time including mid-transfer, asynchronously forces:
  - DaljaValid=4'b0000, Dalja0..3=0, Ptr=2'b00.
  - Held words are discarded.
  - While Reset=0, HyrjaReady evaluates to 1, but no accept occurs.
- First edge after Reset deasserts: normal operation.

Optional Feature:
- Macro DEMUX_1NE4_CNT_EN.
- Defined:
  - Adds output port Numeruesi, 16 bits.
  - Numeruesi increments by 1 on every input accept and wraps 16'hFFFF→0.
  - Reset value 0; async-cleared by Reset.
  - Not affected by Mode.
- Undefined: no port and no counter logic; all other behaviour is identical.

Test Plan:
- Reset check: assert Reset=0 with traffic in flight → DaljaValid=0000, all Dalja=0, Ptr=00 immediately (before any clock edge), and after release.
- Explicit select: Mode=0, S=10, Hyrja=24'hABCDEF, HyrjaValid=1 for one cycle, DaljaReady=0 → Dalja2=ABCDEF, DaljaValid=0100; next word with S=10 → HyrjaReady=0 (stall).
- Drain and reload in the same cycle: channel 1 full, DaljaReady=0010, new accept with S=01 Hyrja=24'h000123 → Dalja1=000123, DaljaValid[1] stays 1, one word per cycle sustained.
- Round-robin wrap: Mode=1, DaljaReady=1111, send 6 words 1..6 → land on channels 0,1,2,3,0,1; Ptr ends at 10.
- Round-robin stall: Mode=1, Ptr=11, channel 3 full with DaljaReady[3]=0 → HyrjaReady=0 and Ptr holds at 11; raise DaljaReady[3] → accept, Ptr wraps to 00.
- With DEMUX_1NE4_CNT_EN: 65537 accepts from reset → Numeruesi=1; reset mid-stream → 0.
